// File: rtl/ball_i2c_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ball_i2c_tx_if
// Description : Bundle between the game controller and the ball hand-off
//               I2C transmitter. It carries the send request, the ball state,
//               the open-drain line controls and the status flags.
//               The master modport is the transmitter side. The slave modport
//               is the controller/line side.
// Signals     : ball_send_trigger  level send request (held until done)
//               ball_y[9:0]        ball y position
//               ball_vy[7:0]       signed y velocity
//               gravity_counter    gravity phase (2 bits)
//               ball_fast          1 = base period, 0 = half period
//               sda_in             sampled SDA line level
//               scl_oe / sda_oe    1 pulls the line low
//               busy               transaction in progress
//               is_i2c_master_done one-cycle end-of-frame pulse
//               nack_error         a NACK was seen in the current/last frame
// Revision    : 1.0 - initial release
// ============================================================================
interface ball_i2c_tx_if;
    logic       ball_send_trigger;
    logic [9:0] ball_y;
    logic [7:0] ball_vy;
    logic [1:0] gravity_counter;
    logic       ball_fast;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic       busy;
    logic       is_i2c_master_done;
    logic       nack_error;

    modport master (
        input  ball_send_trigger, ball_y, ball_vy, gravity_counter, ball_fast, sda_in,
        output scl_oe, sda_oe, busy, is_i2c_master_done, nack_error
    );

    modport slave (
        output ball_send_trigger, ball_y, ball_vy, gravity_counter, ball_fast, sda_in,
        input  scl_oe, sda_oe, busy, is_i2c_master_done, nack_error
    );
endinterface
`default_nettype wire

// File: rtl/ball_i2c_tx.sv
`default_nettype none
// ============================================================================
// Module      : ball_i2c_tx
// Description : Transmit end of the inter-board ball hand-off link. On a rising
//               edge of the send trigger it latches the ball state. It then
//               writes the frame {addr+W, D0..D4} as an open-drain I2C master.
//               It finishes with a one-cycle done pulse.
//               Optional macro BALL_TX_CHECKSUM_EN appends D5 = D0^D1^D2^D3^D4.
// Ports       : clk_25MHZ - system clock
//               reset     - synchronous, active-high
//               bus       - ball_i2c_tx_if.master (trigger, ball state, sda_in,
//                           scl_oe, sda_oe, busy, done pulse, nack_error)
// Parameters  : SLAVE_ADDR - 7-bit peer address
//               CLK_DIV    - clocks per SCL quarter-phase, legal range 2..1023
// Revision    : 1.0 - initial release
// ============================================================================
module ball_i2c_tx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         CLK_DIV    = 62
) (
    input  wire logic      clk_25MHZ,
    input  wire logic      reset,
    ball_i2c_tx_if.master  bus
);

`ifdef BALL_TX_CHECKSUM_EN
    localparam logic [2:0] c_LAST_BYTE = 3'd6;   // A0, D0..D5
`else
    localparam logic [2:0] c_LAST_BYTE = 3'd5;   // A0, D0..D4
`endif
    localparam logic [9:0] c_Q_LAST = 10'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     r_state;
    logic [9:0] r_q;        // clock count inside one quarter-phase
    logic [1:0] r_qtr;      // quarter index inside the current step
    logic [3:0] r_bit;      // bit index within the byte, 0..7
    logic [2:0] r_byte;     // byte index within the frame, 0 = address
    logic [7:0] r_shift;    // MSB is the bit currently on SDA
    logic [9:0] r_y;
    logic [7:0] r_vy;
    logic [1:0] r_grav;
    logic       r_fast;
    logic       r_trig_d;
    logic       r_scl_oe;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_done;
    logic       r_nack;

    logic       w_q_tc;
    logic       w_trig_edge;
    logic [2:0] w_next_idx;
    logic [7:0] w_next_byte;

    assign w_q_tc      = (r_q == c_Q_LAST);
    assign w_trig_edge = bus.ball_send_trigger & ~r_trig_d;

    // Payload byte that follows the current one, built from the latched state.
    always_comb begin
        w_next_idx  = r_byte + 3'd1;
        w_next_byte = 8'h00;
        case (w_next_idx)
            3'd1: w_next_byte = {r_y[9:8], 6'b0};
            3'd2: w_next_byte = r_y[7:0];
            3'd3: w_next_byte = r_vy;
            3'd4: w_next_byte = {6'b0, r_grav};
            3'd5: w_next_byte = {7'b0, r_fast};
`ifdef BALL_TX_CHECKSUM_EN
            3'd6: w_next_byte = {r_y[9:8], 6'b0} ^ r_y[7:0] ^ r_vy ^ {6'b0, r_grav} ^ {7'b0, r_fast};
`endif
            default: w_next_byte = 8'h00;
        endcase
    end

    // The line controls are registered. Each transition loads the line
    // levels for the quarter that is being entered.
    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_qtr    <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_shift  <= '0;
            r_y      <= '0;
            r_vy     <= '0;
            r_grav   <= '0;
            r_fast   <= 1'b0;
            r_trig_d <= 1'b0;
            r_scl_oe <= 1'b0;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_nack   <= 1'b0;
        end else begin
            r_trig_d <= bus.ball_send_trigger;
            r_done   <= 1'b0;

            if (r_state == S_START || r_state == S_BIT ||
                r_state == S_ACK   || r_state == S_STOP) begin
                r_q <= w_q_tc ? 10'd0 : r_q + 10'd1;
            end else begin
                r_q <= 10'd0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_trig_edge) begin
                        r_y      <= bus.ball_y;
                        r_vy     <= bus.ball_vy;
                        r_grav   <= bus.gravity_counter;
                        r_fast   <= bus.ball_fast;
                        r_nack   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_qtr    <= 2'd0;
                        r_bit    <= 4'd0;
                        r_byte   <= 3'd0;
                        r_shift  <= {SLAVE_ADDR, 1'b0};
                        r_sda_oe <= 1'b1;        // START: SDA falls while SCL high
                        r_scl_oe <= 1'b0;
                        r_state  <= S_START;
                    end
                end

                S_START: begin
                    if (w_q_tc) begin
                        if (r_qtr == 2'd0) begin
                            r_qtr    <= 2'd1;
                            r_scl_oe <= 1'b1;
                        end else begin
                            r_qtr    <= 2'd0;
                            r_sda_oe <= ~r_shift[7];
                            r_state  <= S_BIT;
                        end
                    end
                end

                S_BIT: begin
                    if (w_q_tc) begin
                        r_qtr <= r_qtr + 2'd1;
                        case (r_qtr)
                            2'd1: r_scl_oe <= 1'b0;
                            2'd3: begin
                                r_scl_oe <= 1'b1;
                                if (r_bit == 4'd7) begin
                                    r_bit    <= 4'd0;
                                    r_sda_oe <= 1'b0;    // release for the slave ACK
                                    r_state  <= S_ACK;
                                end else begin
                                    r_bit    <= r_bit + 4'd1;
                                    r_shift  <= {r_shift[6:0], 1'b0};
                                    r_sda_oe <= ~r_shift[6];
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_ACK: begin
                    if (w_q_tc) begin
                        r_qtr <= r_qtr + 2'd1;
                        case (r_qtr)
                            2'd1: r_scl_oe <= 1'b0;
                            2'd2: if (bus.sda_in) r_nack <= 1'b1;
                            2'd3: begin
                                r_scl_oe <= 1'b1;
                                if (r_nack || r_byte == c_LAST_BYTE) begin
                                    r_sda_oe <= 1'b1;
                                    r_state  <= S_STOP;
                                end else begin
                                    r_byte   <= w_next_idx;
                                    r_shift  <= w_next_byte;
                                    r_sda_oe <= ~w_next_byte[7];
                                    r_state  <= S_BIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STOP: begin
                    if (w_q_tc) begin
                        r_qtr <= r_qtr + 2'd1;
                        case (r_qtr)
                            2'd0: r_scl_oe <= 1'b0;
                            2'd1: r_sda_oe <= 1'b0;  // SDA rises while SCL high
                            default: begin
                                r_qtr   <= 2'd0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.scl_oe             = r_scl_oe;
    assign bus.sda_oe             = r_sda_oe;
    assign bus.busy               = r_busy;
    assign bus.is_i2c_master_done = r_done;
    assign bus.nack_error         = r_nack;

endmodule
`default_nettype wire

// File: tb/tb_ball_i2c_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_i2c_tx
// Description : Self-checking bench for ball_i2c_tx. An I2C slave model on the
//               open-drain lines decodes the bytes and returns ACK or NACK.
//               Frames come from a vector table and from random ball states,
//               and each is compared with a reference built from the frame
//               rules. Hand-written sequences cover the held trigger and
//               reset during a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_i2c_tx;

    localparam int Q = 4;
`ifdef BALL_TX_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ball_i2c_tx_if bus();

    logic pull = 1'b0;                 // slave model pulling SDA low
    assign bus.sda_in = ~bus.sda_oe & ~pull;

    ball_i2c_tx #(.SLAVE_ADDR(7'h42), .CLK_DIV(Q)) dut (
        .clk_25MHZ (clk),
        .reset     (reset),
        .bus       (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.is_i2c_master_done) done_cnt <= done_cnt + 1;

    // ---------------- I2C slave / bus decoder ----------------
    wire  scl_line = ~bus.scl_oe;
    wire  sda_line = bus.sda_in;
    logic scl_p = 1'b1, sda_p = 1'b1, in_frame = 1'b0;
    int   bit_idx = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] got[$];
    int   nack_at = -1;

    always @(negedge clk) begin
        if (scl_p && scl_line && sda_p && !sda_line) begin
            bit_idx  <= 0;
            pull     <= 1'b0;
            in_frame <= 1'b1;
        end else if (scl_p && scl_line && !sda_p && sda_line) begin
            in_frame <= 1'b0;
        end else if (in_frame && !scl_p && scl_line) begin
            if (bit_idx < 8) begin
                sh      <= {sh[6:0], sda_line};
                bit_idx <= bit_idx + 1;
            end else begin
                got.push_back(sh);
                bit_idx <= 0;
            end
        end else if (in_frame && scl_p && !scl_line) begin
            pull <= (bit_idx == 8) && (got.size() != nack_at);
        end
        scl_p <= scl_line;
        sda_p <= sda_line;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: no done pulse within the cycle budget", name);
    endtask

    // Reference frame byte k (0 = address) from the frame rules.
    function automatic logic [7:0] model_byte(input int k, input logic [9:0] y,
                                              input logic [7:0] vy, input logic [1:0] g,
                                              input logic f);
        int d [7];
        d[0] = 'h42 * 2;
        d[1] = (int'(y) / 256) * 64;
        d[2] = int'(y) % 256;
        d[3] = int'(vy);
        d[4] = int'(g);
        d[5] = int'(f);
        d[6] = d[1] ^ d[2] ^ d[3] ^ d[4] ^ d[5];
        return 8'(d[k]);
    endfunction

    function automatic int model_latency(input int nsent);
        return 1 + (2 + 36 * nsent + 3) * Q;
    endfunction

    // Run one frame: produce an edge, wait for done and report the latency.
    task automatic send(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g,
                        input logic f, input int nack, input bit scramble, output int lat);
        int t0;
        @(negedge clk);
        bus.ball_send_trigger = 1'b0;
        @(negedge clk);
        bus.ball_y = y; bus.ball_vy = vy; bus.gravity_counter = g; bus.ball_fast = f;
        nack_at = nack;
        got.delete();
        bus.ball_send_trigger = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check("busy_start", 32'(bus.busy), 32'd1);
        check("nack_cleared", 32'(bus.nack_error), 32'd0);
        lat = -1;
        for (int i = 0; i < 5000; i++) begin
            if (scramble && i == 8) begin
                bus.ball_y = ~y; bus.ball_vy = ~vy; bus.gravity_counter = ~g; bus.ball_fast = ~f;
            end
            if (bus.is_i2c_master_done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) note_timeout("frame_done");
        @(negedge clk);
        check("done_one_cycle", 32'(bus.is_i2c_master_done), 32'd0);
        check("busy_end", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [9:0] y, input logic [7:0] vy,
                               input logic [1:0] g, input logic f, input int nack, input int lat);
        int nsent;
        nsent = (nack >= 0 && nack < NB) ? nack + 1 : NB;
        check({tag, "_latency"}, 32'(lat), 32'(model_latency(nsent)));
        check({tag, "_nack"}, 32'(bus.nack_error), 32'(nack >= 0 && nack < NB));
        check({tag, "_nbytes"}, 32'(got.size()), 32'(nsent));
        for (int k = 0; k < nsent && k < got.size(); k++)
            check({tag, "_byte"}, 32'(got[k]), 32'(model_byte(k, y, vy, g, f)));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [9:0]  y;
        logic [7:0]  vy;
        logic [1:0]  g;
        logic        f;
        int          nack_at;
        int          n_sent;     // 0 = whole frame
        logic        nack;
        logic [39:0] data;       // expected D0..D4
        bit          scramble;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   lat;
        int   n;
        int   d0;
        int   busy_cycles;
        logic [7:0] exp_b;
        logic [7:0] cks;

        vecs[0] = '{10'h2A5, 8'hFD, 2'd2, 1'b1, -1, 0, 1'b0, 40'h80_A5_FD_02_01, 1'b0};
        vecs[1] = '{10'h2A5, 8'hFD, 2'd2, 1'b1,  2, 3, 1'b1, 40'h80_A5_FD_02_01, 1'b0};
        vecs[2] = '{10'h3FF, 8'h80, 2'd3, 1'b0, -1, 0, 1'b0, 40'hC0_FF_80_03_00, 1'b0};
        vecs[3] = '{10'h000, 8'h7F, 2'd0, 1'b1,  0, 1, 1'b1, 40'h00_00_7F_00_01, 1'b0};
        vecs[4] = '{10'h155, 8'h01, 2'd1, 1'b0,  5, 6, 1'b1, 40'h40_55_01_01_00, 1'b0};
        vecs[5] = '{10'h1C3, 8'h9A, 2'd1, 1'b1, -1, 0, 1'b0, 40'h40_C3_9A_01_01, 1'b1};

        reset = 1'b1;
        bus.ball_send_trigger = 1'b0;
        bus.ball_y = '0; bus.ball_vy = '0; bus.gravity_counter = '0; bus.ball_fast = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_scl_oe", 32'(bus.scl_oe), 32'd0);
        check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.is_i2c_master_done), 32'd0);
        check("rst_nack", 32'(bus.nack_error), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].y, vecs[v].vy, vecs[v].g, vecs[v].f, vecs[v].nack_at, vecs[v].scramble, lat);
            n = (vecs[v].n_sent == 0) ? NB : vecs[v].n_sent;
            check("tbl_latency", 32'(lat), 32'(1 + (5 + 36 * n) * Q));
            check("tbl_nack", 32'(bus.nack_error), 32'(vecs[v].nack));
            check("tbl_nbytes", 32'(got.size()), 32'(n));
            cks = vecs[v].data[39:32] ^ vecs[v].data[31:24] ^ vecs[v].data[23:16]
                ^ vecs[v].data[15:8] ^ vecs[v].data[7:0];
            for (int k = 0; k < n && k < got.size(); k++) begin
                if (k == 0)      exp_b = 8'h84;
                else if (k <= 5) exp_b = vecs[v].data[8 * (5 - k) +: 8];
                else             exp_b = cks;
                check("tbl_byte", 32'(got[k]), 32'(exp_b));
            end
        end

        // Trigger held high long after done: no second frame
        send(10'h2A5, 8'hFD, 2'd2, 1'b1, -1, 1'b0, lat);
        check_frame("hold1", 10'h2A5, 8'hFD, 2'd2, 1'b1, -1, lat);
        d0 = done_cnt;
        busy_cycles = 0;
        repeat (2000) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
        end
        check("held_busy_cycles", 32'(busy_cycles), 32'd0);
        check("held_done_pulses", 32'(done_cnt - d0), 32'd0);
        send(10'h0F0, 8'h11, 2'd3, 1'b0, -1, 1'b0, lat);
        check_frame("rearm", 10'h0F0, 8'h11, 2'd3, 1'b0, -1, lat);

        // Reset while D2 is on the wire
        @(negedge clk);
        bus.ball_send_trigger = 1'b0;
        @(negedge clk);
        bus.ball_y = 10'h2A5; bus.ball_vy = 8'hFD; bus.gravity_counter = 2'd2; bus.ball_fast = 1'b1;
        nack_at = -1;
        got.delete();
        bus.ball_send_trigger = 1'b1;
        for (int i = 0; i < 3000 && got.size() < 3; i++) @(negedge clk);
        if (got.size() < 3) note_timeout("reset_reach_d2");
        repeat (6 * Q) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_scl_oe", 32'(bus.scl_oe), 32'd0);
        check("midrst_sda_oe", 32'(bus.sda_oe), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        bus.ball_send_trigger = 1'b0;
        repeat (4) @(negedge clk);
        send(10'h2A5, 8'hFD, 2'd2, 1'b1, -1, 1'b0, lat);
        check_frame("after_rst", 10'h2A5, 8'hFD, 2'd2, 1'b1, -1, lat);

        // Random ball states against the reference model
        for (int r = 0; r < 8; r++) begin
            logic [9:0] ry;
            logic [7:0] rvy;
            logic [1:0] rg;
            logic       rf;
            int         rn;
            ry  = 10'($urandom);
            rvy = 8'($urandom);
            rg  = 2'($urandom);
            rf  = 1'($urandom);
            rn  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            send(ry, rvy, rg, rf, rn, 1'b0, lat);
            check_frame("rnd", ry, rvy, rg, rf, rn, lat);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
